// File: rtl/writeback_if.sv
// Bus bundle between execute/LSU, the writeback unit and the regfile write port.
// The master side is the upstream pipeline and regfile; the slave side is writeback_unit.
interface writeback_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue_valid;
  logic        ld_issue_ready;
  logic [4:0]  ld_issue_rd;
  logic [2:0]  ld_issue_funct3;
  logic [1:0]  ld_issue_offset;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_data;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        hazard_rs1;
  logic        hazard_rs2;
  logic        err_underflow;

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output ld_issue_valid, ld_issue_rd, ld_issue_funct3, ld_issue_offset,
    input  ld_issue_ready,
    output mem_rvalid, mem_rdata,
    input  rf_we, rf_rd_addr, rf_data,
    output chk_rs1, chk_rs2,
    input  hazard_rs1, hazard_rs2, err_underflow
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  ld_issue_valid, ld_issue_rd, ld_issue_funct3, ld_issue_offset,
    output ld_issue_ready,
    input  mem_rvalid, mem_rdata,
    output rf_we, rf_rd_addr, rf_data,
    input  chk_rs1, chk_rs2,
    output hazard_rs1, hazard_rs2, err_underflow
  );
endinterface

// File: rtl/writeback_unit.sv
// Merges ALU results and in-order load returns into the single regfile write port.
// Define WB_HAZARD_EN for exact per-entry hazard compares; otherwise hazards are conservative.
module writeback_unit #(
  parameter int RV32E    = 0,
  parameter int LQ_DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clk_en,
  writeback_if.slave wb
);
  localparam int         PW       = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam logic [4:0] RMASK    = (RV32E != 0) ? 5'h0F : 5'h1F;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(LQ_DEPTH);

  logic [4:0]    lq_rd_q  [LQ_DEPTH];
  logic [4:0]    lq_rd_d  [LQ_DEPTH];
  logic [2:0]    lq_f3_q  [LQ_DEPTH];
  logic [2:0]    lq_f3_d  [LQ_DEPTH];
  logic [1:0]    lq_off_q [LQ_DEPTH];
  logic [1:0]    lq_off_d [LQ_DEPTH];
  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          skid_vld_q, skid_vld_d;
  logic [4:0]    skid_rd_q, skid_rd_d;
  logic [31:0]   skid_data_q, skid_data_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_addr_q, rf_addr_d;
  logic [31:0]   rf_data_q, rf_data_d;
  logic          err_q, err_d;

  logic lq_empty, lq_full, push, pop, alu_acc;

  function automatic logic rmatch(input logic [4:0] a, input logic [4:0] b);
    return (a & RMASK) == (b & RMASK);
  endfunction

  function automatic logic nz(input logic [4:0] a);
    return (a & RMASK) != 5'd0;
  endfunction

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  assign lq_empty = (cnt_q == '0);
  assign lq_full  = (cnt_q == FULL_CNT);

  assign wb.alu_ready      = !skid_vld_q;
  assign wb.ld_issue_ready = !lq_full;
  assign wb.rf_we          = rf_we_q;
  assign wb.rf_rd_addr     = rf_addr_q;
  assign wb.rf_data        = rf_data_q;
  assign wb.err_underflow  = err_q;

  // clk_en gating lives in the flop enable, so the handshakes here assume an enabled cycle.
  assign push    = wb.ld_issue_valid && !lq_full;
  assign pop     = wb.mem_rvalid && !lq_empty;
  assign alu_acc = wb.alu_valid && !skid_vld_q;

  always_comb begin
    lq_rd_d     = lq_rd_q;
    lq_f3_d     = lq_f3_q;
    lq_off_d    = lq_off_q;
    rptr_d      = rptr_q;
    wptr_d      = wptr_q;
    cnt_d       = cnt_q;
    skid_vld_d  = skid_vld_q;
    skid_rd_d   = skid_rd_q;
    skid_data_d = skid_data_q;
    rf_we_d     = 1'b0;
    rf_addr_d   = rf_addr_q;
    rf_data_d   = rf_data_q;
    err_d       = err_q;

    if (push) begin
      lq_rd_d[wptr_q]  = wb.ld_issue_rd;
      lq_f3_d[wptr_q]  = wb.ld_issue_funct3;
      lq_off_d[wptr_q] = wb.ld_issue_offset;
      wptr_d           = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;

    if (wb.mem_rvalid && lq_empty) err_d = 1'b1;

    // Load returns have no backpressure, so they always own the port; ALU work parks in the skid.
    if (pop) begin
      rf_we_d   = nz(lq_rd_q[rptr_q]);
      rf_addr_d = lq_rd_q[rptr_q];
      rf_data_d = fmt_load(wb.mem_rdata, lq_f3_q[rptr_q], lq_off_q[rptr_q]);
      if (alu_acc) begin
        skid_vld_d  = 1'b1;
        skid_rd_d   = wb.alu_rd;
        skid_data_d = wb.alu_data;
      end
    end else if (skid_vld_q) begin
      rf_we_d    = nz(skid_rd_q);
      rf_addr_d  = skid_rd_q;
      rf_data_d  = skid_data_q;
      skid_vld_d = 1'b0;
    end else if (alu_acc) begin
      rf_we_d   = nz(wb.alu_rd);
      rf_addr_d = wb.alu_rd;
      rf_data_d = wb.alu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq_rd_q[i]  <= '0;
        lq_f3_q[i]  <= '0;
        lq_off_q[i] <= '0;
      end
      rptr_q      <= '0;
      wptr_q      <= '0;
      cnt_q       <= '0;
      skid_vld_q  <= 1'b0;
      skid_rd_q   <= '0;
      skid_data_q <= '0;
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
      err_q       <= 1'b0;
    end else if (clk_en) begin
      lq_rd_q     <= lq_rd_d;
      lq_f3_q     <= lq_f3_d;
      lq_off_q    <= lq_off_d;
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      skid_vld_q  <= skid_vld_d;
      skid_rd_q   <= skid_rd_d;
      skid_data_q <= skid_data_d;
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_data_q   <= rf_data_d;
      err_q       <= err_d;
    end
  end

`ifdef WB_HAZARD_EN
  logic [LQ_DEPTH-1:0] hit1, hit2;
  for (genvar g = 0; g < LQ_DEPTH; g++) begin : g_haz
    logic [PW-1:0] dist;
    logic          ent_vld;
    // An entry is live when its distance from the read pointer is below the occupancy.
    assign dist    = PW'(g) - rptr_q;
    assign ent_vld = ({1'b0, dist} < cnt_q);
    assign hit1[g] = ent_vld && rmatch(lq_rd_q[g], wb.chk_rs1);
    assign hit2[g] = ent_vld && rmatch(lq_rd_q[g], wb.chk_rs2);
  end
  assign wb.hazard_rs1 = nz(wb.chk_rs1) &&
                         ((|hit1) || (skid_vld_q && rmatch(skid_rd_q, wb.chk_rs1)));
  assign wb.hazard_rs2 = nz(wb.chk_rs2) &&
                         ((|hit2) || (skid_vld_q && rmatch(skid_rd_q, wb.chk_rs2)));
`else
  logic unused_chk;
  assign unused_chk    = ^{wb.chk_rs1, wb.chk_rs2};
  assign wb.hazard_rs1 = !lq_empty || skid_vld_q;
  assign wb.hazard_rs2 = !lq_empty || skid_vld_q;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboarded bench for writeback_unit: expected regfile writes are queued as stimulus is
// driven and popped by a write-port monitor; control outputs are checked directly.
module tb_writeback_unit;
  logic clk, rst_n, clk_en;
  writeback_if wb();

  writeback_unit #(.RV32E(0), .LQ_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .wb(wb)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t sbq[$];
  wr_t e;
  int  n_chk = 0;
  int  n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    sbq.push_back(w);
  endtask

  // A write is committed on the next edge only if clk_en is high for that edge.
  always @(negedge clk) begin
    if (rst_n && clk_en && wb.rf_we) begin
      if (sbq.size() == 0) begin
        chk("sb_extra_we", {31'd0, wb.rf_we}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("wb_addr", {27'd0, wb.rf_rd_addr}, {27'd0, e.a});
        chk("wb_data", wb.rf_data, e.d);
      end
    end
  end

  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] raw, input logic [31:0] expv);
    wb.ld_issue_valid  = 1'b1;
    wb.ld_issue_rd     = rd;
    wb.ld_issue_funct3 = f3;
    wb.ld_issue_offset = off;
    tick();
    wb.ld_issue_valid = 1'b0;
    wb.mem_rvalid     = 1'b1;
    wb.mem_rdata      = raw;
    push_exp(rd, expv);
    tick();
    wb.mem_rvalid = 1'b0;
    chk("ld_we", {31'd0, wb.rf_we}, 32'd1);
    chk("ld_data", wb.rf_data, expv);
  endtask

  initial begin
    rst_n = 1'b0;
    clk_en = 1'b1;
    wb.alu_valid = 1'b0;       wb.alu_rd = '0;           wb.alu_data = '0;
    wb.ld_issue_valid = 1'b0;  wb.ld_issue_rd = '0;
    wb.ld_issue_funct3 = '0;   wb.ld_issue_offset = '0;
    wb.mem_rvalid = 1'b0;      wb.mem_rdata = '0;
    wb.chk_rs1 = 5'd5;         wb.chk_rs2 = 5'd6;
    tick();
    tick();
    chk("rst_we", {31'd0, wb.rf_we}, 32'd0);
    chk("rst_addr", {27'd0, wb.rf_rd_addr}, 32'd0);
    chk("rst_data", wb.rf_data, 32'd0);
    chk("rst_err", {31'd0, wb.err_underflow}, 32'd0);
    chk("rst_alu_rdy", {31'd0, wb.alu_ready}, 32'd1);
    chk("rst_ld_rdy", {31'd0, wb.ld_issue_ready}, 32'd1);
    chk("rst_haz", {30'd0, wb.hazard_rs1, wb.hazard_rs2}, 32'd0);
    rst_n = 1'b1;
    tick();

    // plain ALU write, 1-cycle latency
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd5; wb.alu_data = 32'h1234;
    push_exp(5'd5, 32'h0000_1234);
    tick();
    wb.alu_valid = 1'b0;
    chk("alu_we", {31'd0, wb.rf_we}, 32'd1);
    chk("alu_addr", {27'd0, wb.rf_rd_addr}, 32'd5);
    chk("alu_data", wb.rf_data, 32'h0000_1234);
    chk("alu_rdy", {31'd0, wb.alu_ready}, 32'd1);

    // hazard while a load is outstanding
    wb.chk_rs1 = 5'd3;
    wb.ld_issue_valid = 1'b1; wb.ld_issue_rd = 5'd3;
    wb.ld_issue_funct3 = 3'b000; wb.ld_issue_offset = 2'd2;
    tick();
    wb.ld_issue_valid = 1'b0;
    chk("haz_ld", {31'd0, wb.hazard_rs1}, 32'd1);
    wb.mem_rvalid = 1'b1; wb.mem_rdata = 32'h0080_FF00;
    push_exp(5'd3, 32'hFFFF_FF80);
    tick();
    wb.mem_rvalid = 1'b0;
    chk("lb_data", wb.rf_data, 32'hFFFF_FF80);
    chk("haz_clr", {31'd0, wb.hazard_rs1}, 32'd0);

    // load formatting table
    do_load(5'd3,  3'b100, 2'd2, 32'h0080_FF00, 32'h0000_0080);
    do_load(5'd20, 3'b000, 2'd0, 32'h0000_007F, 32'h0000_007F);
    do_load(5'd21, 3'b001, 2'd2, 32'h8001_0000, 32'hFFFF_8001);
    do_load(5'd22, 3'b101, 2'd2, 32'h8001_0000, 32'h0000_8001);
    do_load(5'd23, 3'b010, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load(5'd24, 3'b010, 2'd2, 32'hCAFE_F00D, 32'hCAFE_F00D);
    do_load(5'd25, 3'b011, 2'd1, 32'h1234_5678, 32'h1234_5678);
    do_load(5'd26, 3'b100, 2'd3, 32'hAB00_0000, 32'h0000_00AB);

    // load return collides with ALU result: load first, ALU via skid
    wb.ld_issue_valid = 1'b1; wb.ld_issue_rd = 5'd7;
    wb.ld_issue_funct3 = 3'b010; wb.ld_issue_offset = 2'd0;
    tick();
    wb.ld_issue_valid = 1'b0;
    wb.mem_rvalid = 1'b1; wb.mem_rdata = 32'hAAAA_5555;
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd8; wb.alu_data = 32'h88;
    push_exp(5'd7, 32'hAAAA_5555);
    push_exp(5'd8, 32'h0000_0088);
    tick();
    wb.mem_rvalid = 1'b0; wb.alu_valid = 1'b0;
    chk("col_addr1", {27'd0, wb.rf_rd_addr}, 32'd7);
    chk("col_alu_rdy0", {31'd0, wb.alu_ready}, 32'd0);
    tick();
    chk("col_addr2", {27'd0, wb.rf_rd_addr}, 32'd8);
    chk("col_we2", {31'd0, wb.rf_we}, 32'd1);
    chk("col_alu_rdy1", {31'd0, wb.alu_ready}, 32'd1);

    // fill the queue; a third issue must be refused
    wb.ld_issue_valid = 1'b1; wb.ld_issue_funct3 = 3'b010; wb.ld_issue_offset = 2'd0;
    wb.ld_issue_rd = 5'd10; tick();
    wb.ld_issue_rd = 5'd11; tick();
    wb.ld_issue_rd = 5'd12; tick();
    wb.ld_issue_valid = 1'b0;
    wb.chk_rs1 = 5'd10; wb.chk_rs2 = 5'd12;
    #1;
    chk("full_ld_rdy", {31'd0, wb.ld_issue_ready}, 32'd0);
    chk("full_haz1", {31'd0, wb.hazard_rs1}, 32'd1);
`ifdef WB_HAZARD_EN
    chk("full_haz2", {31'd0, wb.hazard_rs2}, 32'd0);
`else
    chk("full_haz2", {31'd0, wb.hazard_rs2}, 32'd1);
`endif
    wb.mem_rvalid = 1'b1;
    wb.mem_rdata = 32'h10; push_exp(5'd10, 32'h10); tick();
    wb.mem_rdata = 32'h11; push_exp(5'd11, 32'h11); tick();
    wb.mem_rvalid = 1'b0;
    chk("drain_ld_rdy", {31'd0, wb.ld_issue_ready}, 32'd1);
    chk("drain_haz", {30'd0, wb.hazard_rs1, wb.hazard_rs2}, 32'd0);

    // underflow: no write, sticky error
    tick();
    wb.mem_rvalid = 1'b1; wb.mem_rdata = 32'hBAD0_BAD0;
    tick();
    wb.mem_rvalid = 1'b0;
    chk("uf_we", {31'd0, wb.rf_we}, 32'd0);
    chk("uf_err", {31'd0, wb.err_underflow}, 32'd1);
    tick(); tick();
    chk("uf_err_sticky", {31'd0, wb.err_underflow}, 32'd1);

    // rd == 0 never writes
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd0; wb.alu_data = 32'hFFFF_FFFF;
    tick();
    wb.alu_valid = 1'b0;
    chk("x0_we", {31'd0, wb.rf_we}, 32'd0);

    // clock-enable stall holds everything
    clk_en = 1'b0;
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd9; wb.alu_data = 32'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_we", {31'd0, wb.rf_we}, 32'd0);
    end
    clk_en = 1'b1;
    push_exp(5'd9, 32'h99);
    tick();
    wb.alu_valid = 1'b0;
    chk("resume_we", {31'd0, wb.rf_we}, 32'd1);
    chk("resume_addr", {27'd0, wb.rf_rd_addr}, 32'd9);

    // reset mid-operation discards the queue and clears the error flag
    wb.ld_issue_valid = 1'b1; wb.ld_issue_rd = 5'd13;
    tick();
    wb.ld_issue_valid = 1'b0;
    wb.chk_rs1 = 5'd13;
    #1;
    chk("pre_rst_haz", {31'd0, wb.hazard_rs1}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_haz", {31'd0, wb.hazard_rs1}, 32'd0);
    chk("mid_rst_err", {31'd0, wb.err_underflow}, 32'd0);
    chk("mid_rst_ld_rdy", {31'd0, wb.ld_issue_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick(); tick();

    chk("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-port driver for the integer register file. It merges single-cycle ALU results and out-of-order-in-time load returns into the one regfile write port. It tracks outstanding loads in a small in-order queue and sign/zero-extends load data. It also flags source-register hazards against pending writes so the issue stage can stall. It sits between execute/LSU and the regfile's `we`/`rd_addr`/`data_in` inputs.

## Interface
Parameters:
- `RV32E`, 0: 0 means 32 registers, 1 means 16. Address compares use the low 4 bits when set.
- `LQ_DEPTH`, 2: load-queue entries. Power of two, ≥2.

Ports:
- `clk`  in  1  clock; everything is posedge.
- `rst_n`  in  1  async active-low reset.
- `clk_en`  in  1  global stall. When low, all state is frozen.
- `alu_valid`  in  1  ALU result present.
- `alu_ready`  out  1  ALU result accepted.
- `alu_rd`  in  5  destination register for the ALU result.
- `alu_data`  in  32  ALU result.
- `ld_issue_valid`  in  1  load issued to memory.
- `ld_issue_ready`  out  1  queue not full.
- `ld_issue_rd`  in  5  load destination register.
- `ld_issue_funct3`  in  3  load funct3.
- `ld_issue_offset`  in  2  byte address [1:0].
- `mem_rvalid`  in  1  load data returning; no backpressure.
- `mem_rdata`  in  32  raw aligned word.
- `rf_we`  out  1  regfile write enable.
- `rf_rd_addr`  out  5  regfile write address.
- `rf_data`  out  32  regfile write data.
- `chk_rs1`, `chk_rs2`  in  5  issue-stage source registers to check.
- `hazard_rs1`, `hazard_rs2`  out  1  source register has a pending write.
- `err_underflow`  out  1  sticky: `mem_rvalid` arrived with the load queue empty.

## Operation
- Load queue: an in-order FIFO holding {rd, funct3, offset}.
  - Push on `ld_issue_valid && ld_issue_ready`.
  - Pop on `mem_rvalid`.
  - `ld_issue_ready` = queue not full. It is computed from state only; a same-cycle pop does not raise it.
  - Push and pop in the same cycle leave the count unchanged.
- Load formatting from the head entry:
  - Shift `mem_rdata` right by offset×8.
  - LB (000) and LH (001) sign-extend.
  - LBU (100) and LHU (101) zero-extend.
  - LW (010) passes the word unshifted.
  - Any other funct3 passes the raw word.
- ALU skid buffer: one entry {rd, data}. `alu_ready` = skid empty.
- Write-port priority each enabled cycle: load return > skid > new ALU.
  - Load return with an accepted ALU result: the ALU result goes to the skid.
  - Load return with the skid full: the skid holds.
  - No load return with the skid full: the skid drains, and no new ALU result is taken that cycle.
  - No load return with the skid empty: an accepted ALU result writes directly.
- A winner with rd == 0 still pops its source but drives `rf_we` = 0.
- `mem_rvalid` with the queue empty: no write, no pop, `err_underflow` ← 1. The flag clears only on reset.
- Hazard: `hazard_rsN` = 1 iff `chk_rsN` ≠ 0 and it equals the rd of any valid queue entry or of the skid.
- Reset mid-operation: the queue and skid are discarded. The LSU must also discard in-flight loads.

## Timing
- `rf_we`, `rf_rd_addr`, `rf_data` are registered. They are valid one cycle after the accepting edge of the source event. The regfile commits them on the following edge.
- `alu_ready`, `ld_issue_ready` and the hazard outputs are combinational from registered state only.
- Reset values:
  - `rf_we`, `rf_rd_addr`, `rf_data`, `err_underflow`: 0.
  - `alu_ready`, `ld_issue_ready`: 1.
  - Hazard outputs: 0.
  - Queue empty, skid empty.
- With `clk_en` low, no pushes, pops or writes occur. The registered outputs hold their values, and the regfile ignores them because it is clock-enabled. Upstream guarantees `mem_rvalid` is low while `clk_en` is low.
- Latency: ALU to `rf_we` is 1 cycle with no collision, or 2 cycles via the skid. Load return to `rf_we` is always 1 cycle.

## Configuration
- `WB_HAZARD_EN` defined: the hazard comparators are built as described above.
- `WB_HAZARD_EN` undefined:
  - `hazard_rs1` and `hazard_rs2` are both 1 whenever the queue or the skid is non-empty, and 0 otherwise.
  - The issue stage stalls conservatively.
  - No per-entry comparators are built.

## Test plan
- Reset, then `alu_valid` with rd=5, data=0x1234 → next cycle `rf_we`=1, addr=5, data=0x00001234, and `alu_ready` stays 1.
- Issue LB with rd=3, offset=2, then `mem_rvalid` with `mem_rdata`=0x0080FF00 → `rf_data`=0xFFFFFF80. The same stimulus as LBU gives 0x00000080.
- `mem_rvalid` (rd=7) and `alu_valid` (rd=8) in the same cycle → cycle+1 writes x7, cycle+2 writes x8, and `alu_ready` is 0 during cycle+1.
- Issue two loads with `LQ_DEPTH`=2 → `ld_issue_ready`=0. `chk_rs1`=the first rd gives `hazard_rs1`=1. After both returns the outputs are 1/0.
- `mem_rvalid` with the queue empty → no `rf_we`, and `err_underflow`=1 until `rst_n` is asserted.
- ALU result with rd=0 → `rf_we` stays 0. `clk_en`=0 with `alu_valid` held → no write until `clk_en` returns.
